alu_seq: RTL and testbench

//  Multi-op handshaked ALU, parametrised in data width.

---
 rtl/alu_seq.sv | 170 +++++++++++++++++
 tb/tb_alu_seq.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// alu_seq: handshaked multi-op ALU with registered result and EQ flag.
// Single-cycle ops (add/sub/logic/compare) complete in one cycle. Shifts
// run one bit per cycle. The optional unsigned shift-add multiplier is
// enabled by defining the macro ALU_MUL_EN.
module alu_seq #(
    parameter int DATA_SIZE = 32,
    parameter int SHAMT_W   = $clog2(DATA_SIZE)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DATA_SIZE-1:0] ALUop1,
    input  logic [DATA_SIZE-1:0] ALUop2,
    input  logic [3:0]           ALUctrl,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DATA_SIZE-1:0] ALUout,
    output logic                 EQ,
    output logic                 busy
);

    localparam int CNT_W = SHAMT_W + 1;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b0010;
    localparam logic [3:0] OP_OR   = 4'b0011;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_SLT  = 4'b0101;
    localparam logic [3:0] OP_SLTU = 4'b0110;
    localparam logic [3:0] OP_SLL  = 4'b0111;
    localparam logic [3:0] OP_SRL  = 4'b1000;
    localparam logic [3:0] OP_SRA  = 4'b1001;
`ifdef ALU_MUL_EN
    localparam logic [3:0] OP_MUL  = 4'b1010;
`endif

    typedef enum logic [1:0] {IDLE, EXEC, HOLD} state_t;

    state_t                 state_q, state_d;
    logic [DATA_SIZE-1:0]   res_q, res_d;
    logic                   eq_q, eq_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [3:0]             ctrl_q, ctrl_d;
`ifdef ALU_MUL_EN
    logic [DATA_SIZE-1:0]   mcand_q, mcand_d;
    logic [DATA_SIZE-1:0]   mplier_q, mplier_d;
`endif

    logic                   accept;
    logic [SHAMT_W-1:0]     shamt;

    // Result of every op that finishes in the accept cycle; shifts and
    // unused opcodes fall through to zero here.
    function automatic logic [DATA_SIZE-1:0] single_op(
        input logic [DATA_SIZE-1:0] a,
        input logic [DATA_SIZE-1:0] b,
        input logic [3:0]           op
    );
        logic [DATA_SIZE-1:0] r;
        r = '0;
        case (op)
            OP_ADD:  r = a + b;
            OP_SUB:  r = a - b;
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_XOR:  r = a ^ b;
            OP_SLT:  r = {{(DATA_SIZE-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLTU: r = {{(DATA_SIZE-1){1'b0}}, (a < b)};
            default: r = '0;
        endcase
        return r;
    endfunction

    assign in_ready  = (state_q == IDLE) || ((state_q == HOLD) && out_ready);
    assign accept    = in_valid && in_ready;
    assign shamt     = ALUop2[SHAMT_W-1:0];
    assign out_valid = (state_q == HOLD);
    assign busy      = (state_q == EXEC);
    assign ALUout    = res_q;
    assign EQ        = eq_q;

    // Next-state: iterate in EXEC, retire from HOLD, and capture a new op on accept.
    always_comb begin
        state_d  = state_q;
        res_d    = res_q;
        eq_d     = eq_q;
        cnt_d    = cnt_q;
        ctrl_d   = ctrl_q;
`ifdef ALU_MUL_EN
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
`endif
        case (state_q)
            EXEC: begin
                case (ctrl_q)
                    OP_SLL:  res_d = res_q << 1;
                    OP_SRL:  res_d = res_q >> 1;
                    OP_SRA:  res_d = {res_q[DATA_SIZE-1], res_q[DATA_SIZE-1:1]};
`ifdef ALU_MUL_EN
                    OP_MUL: begin
                        if (mplier_q[0]) res_d = res_q + mcand_q;
                        mcand_d  = mcand_q << 1;
                        mplier_d = mplier_q >> 1;
                    end
`endif
                    default: res_d = res_q;
                endcase
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) state_d = HOLD;
            end
            HOLD: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // A new op may start from IDLE or in the same edge HOLD retires.
        if (accept) begin
            ctrl_d = ALUctrl;
            eq_d   = (ALUop1 == ALUop2);
            case (ALUctrl)
                OP_SLL, OP_SRL, OP_SRA: begin
                    res_d = ALUop1;
                    cnt_d = {1'b0, shamt};
                    state_d = (shamt == '0) ? HOLD : EXEC;
                end
`ifdef ALU_MUL_EN
                OP_MUL: begin
                    res_d    = '0;
                    mcand_d  = ALUop1;
                    mplier_d = ALUop2;
                    cnt_d    = CNT_W'(DATA_SIZE);
                    state_d  = EXEC;
                end
`endif
                default: begin
                    res_d   = single_op(ALUop1, ALUop2, ALUctrl);
                    state_d = HOLD;
                end
            endcase
        end
    end

    // Control and visible result registers; reset discards any in-flight op.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            res_q   <= '0;
            eq_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            res_q   <= res_d;
            eq_q    <= eq_d;
            cnt_q   <= cnt_d;
        end
    end

    // Captured opcode and multiplier operands; only meaningful after an accept.
    always_ff @(posedge clk) begin
        ctrl_q   <= ctrl_d;
`ifdef ALU_MUL_EN
        mcand_q  <= mcand_d;
        mplier_q <= mplier_d;
`endif
    end

endmodule

// File: tb/tb_alu_seq.sv
// Testbench for alu_seq (DATA_SIZE=32). Define ALU_MUL_EN to cover the multiplier.
module tb_alu_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] ALUop1 = '0;
    logic [31:0] ALUop2 = '0;
    logic [3:0]  ALUctrl = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] ALUout;
    logic        EQ;
    logic        busy;

    int checks = 0;
    int errors = 0;

    alu_seq #(.DATA_SIZE(32)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .ALUop1(ALUop1), .ALUop2(ALUop2), .ALUctrl(ALUctrl),
        .out_valid(out_valid), .out_ready(out_ready),
        .ALUout(ALUout), .EQ(EQ), .busy(busy)
    );

    always #5 clk = ~clk;

    // Reference model: result from plain arithmetic on the opcode's meaning.
    function automatic logic [31:0] model_res(input logic [31:0] a, input logic [31:0] b,
                                              input logic [3:0] c);
        logic [4:0] sh;
        sh = b[4:0];
        case (c)
            4'd0:  return a + b;
            4'd1:  return a - b;
            4'd2:  return a & b;
            4'd3:  return a | b;
            4'd4:  return a ^ b;
            4'd5:  return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
            4'd6:  return (a < b) ? 32'd1 : 32'd0;
            4'd7:  return a << sh;
            4'd8:  return a >> sh;
            4'd9:  return 32'(int'(a) >>> sh);
`ifdef ALU_MUL_EN
            4'd10: return 32'(64'(a) * 64'(b));
`endif
            default: return 32'd0;
        endcase
    endfunction

    // Cycles from accept edge until out_valid is seen.
    function automatic int model_lat(input logic [31:0] b, input logic [3:0] c);
        if (c == 4'd7 || c == 4'd8 || c == 4'd9) return 1 + int'(b[4:0]);
`ifdef ALU_MUL_EN
        if (c == 4'd10) return 33;
`endif
        return 1;
    endfunction

    // Issue one op, keep garbage on the inputs while it runs, check result/EQ/latency.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [3:0] c,
                          input string nm);
        logic [31:0] exp_r;
        logic        exp_eq;
        int          exp_l;
        int          lat;
        bit          got;
        bit          bad;
        exp_r  = model_res(a, b, c);
        exp_eq = (a == b);
        exp_l  = model_lat(b, c);
        @(negedge clk);
        out_ready = 1'b1;
        in_valid = 1'b1; ALUop1 = a; ALUop2 = b; ALUctrl = c;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL %s in_ready at issue: got %b want 1", nm, in_ready);
        end
        @(posedge clk); #1;
        ALUop1 = $urandom; ALUop2 = $urandom; ALUctrl = 4'($urandom);
        lat = 0; got = 0; bad = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            lat++;
            if (out_valid === 1'b1) begin
                got = 1; in_valid = 1'b0;
                break;
            end
            if (in_ready !== 1'b0 || busy !== 1'b1) bad = 1;
        end
        in_valid = 1'b0;
        checks++;
        if (!got) begin
            errors++; $display("FAIL %s timeout: out_valid never rose, want latency %0d", nm, exp_l);
            return;
        end
        if (ALUout !== exp_r) begin
            errors++; $display("FAIL %s result: got %h want %h", nm, ALUout, exp_r);
        end
        checks++;
        if (EQ !== exp_eq) begin
            errors++; $display("FAIL %s EQ: got %b want %b", nm, EQ, exp_eq);
        end
        checks++;
        if (lat != exp_l) begin
            errors++; $display("FAIL %s latency: got %0d want %0d", nm, lat, exp_l);
        end
        if (exp_l > 1) begin
            checks++;
            if (bad) begin
                errors++; $display("FAIL %s exec_ctrl: in_ready/busy wrong while iterating, got bad=%0d want 0", nm, bad);
            end
        end
    endtask

    task automatic test_reset();
        bit seen;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL reset_init in_ready: got %b want 1", in_ready);
        end
        // Start SLL by 20 with equal operands so EQ would be 1 if not cleared.
        in_valid = 1'b1; ALUop1 = 32'd20; ALUop2 = 32'd20; ALUctrl = 4'd7; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin
            errors++; $display("FAIL reset_pre busy: got %b want 1", busy);
        end
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || ALUout !== 32'd0 || EQ !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_exec: got ov=%b out=%h eq=%b busy=%b want 0/0/0/0",
                     out_valid, ALUout, EQ, busy);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL reset_release in_ready: got %b want 1", in_ready);
        end
        seen = 0;
        repeat (25) begin
            @(negedge clk);
            if (out_valid !== 1'b0 || busy !== 1'b0) seen = 1;
        end
        checks++;
        if (seen) begin
            errors++; $display("FAIL reset_discard: got stale activity after reset, want none");
        end
    endtask

    task automatic test_arith();
        run_op(32'hFFFF_FFFF, 32'h0000_0002, 4'd0, "add_wrap");
        run_op(32'd5, 32'd5, 4'd1, "sub_equal");
        run_op(32'h8000_0000, 32'd1, 4'd5, "slt_neg");
        run_op(32'h8000_0000, 32'd1, 4'd6, "sltu_big");
        run_op(32'hF0F0_1234, 32'h0FF0_4321, 4'd2, "and");
        run_op(32'hF0F0_1234, 32'h0FF0_4321, 4'd3, "or");
    endtask

    task automatic test_shift();
        run_op(32'h8000_0000, 32'd4, 4'd9, "sra_4");
        run_op(32'h1234_5678, 32'hFFFF_FFE3, 4'd7, "sll_upper_ignored");
        run_op(32'h8765_4321, 32'd7, 4'd8, "srl_7");
    endtask

    task automatic test_boundaries();
        run_op(32'hDEAD_BEEF, 32'd0, 4'd7, "sll_zero");
        run_op(32'h8000_0000, 32'hFFFF_FFFF, 4'd8, "srl_31");
        run_op(32'hABCD_0001, 32'hABCD_0001, 4'd15, "op_unused");
        run_op(32'h7FFF_FFFF, 32'h8000_0000, 4'd5, "slt_pos_vs_neg");
    endtask

    task automatic test_mul();
`ifdef ALU_MUL_EN
        run_op(32'h0001_0000, 32'h0001_0001, 4'd10, "mul_wide");
        run_op(32'd12345, 32'd6789, 4'd10, "mul_small");
`else
        run_op(32'h0001_0000, 32'h0001_0001, 4'd10, "op1010_unused");
`endif
    endtask

    task automatic test_backpressure();
        logic [31:0] a;
        logic [31:0] exp_r;
        bit          bad;
        a = $urandom;
        exp_r = a + a;
        @(negedge clk);
        out_ready = 1'b0;
        in_valid = 1'b1; ALUop1 = a; ALUop2 = a; ALUctrl = 4'd0;
        @(posedge clk); #1;
        ALUop1 = $urandom; ALUop2 = $urandom; ALUctrl = 4'd4;
        bad = 0;
        repeat (3) begin
            @(negedge clk);
            if (out_valid !== 1'b1 || ALUout !== exp_r || EQ !== 1'b1 || in_ready !== 1'b0) bad = 1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL backpressure_hold: got ov=%b out=%h eq=%b ir=%b want 1/%h/1/0",
                     out_valid, ALUout, EQ, in_ready, exp_r);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL backpressure_release out_valid: got %b want 0", out_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] qa[$];
        logic [31:0] qb[$];
        logic [31:0] exp_r;
        for (int i = 0; i < 4; i++) begin
            qa.push_back($urandom);
            qb.push_back($urandom);
        end
        out_ready = 1'b1;
        for (int i = 0; i <= 4; i++) begin
            @(negedge clk);
            if (i > 0) begin
                exp_r = qa[i-1] ^ qb[i-1];
                checks++;
                if (out_valid !== 1'b1 || ALUout !== exp_r) begin
                    errors++;
                    $display("FAIL stream_%0d: got ov=%b out=%h want 1/%h", i-1, out_valid, ALUout, exp_r);
                end
                checks++;
                if (in_ready !== 1'b1) begin
                    errors++; $display("FAIL stream_%0d in_ready: got %b want 1", i-1, in_ready);
                end
            end
            if (i < 4) begin
                in_valid = 1'b1; ALUop1 = qa[i]; ALUop2 = qb[i]; ALUctrl = 4'd4;
            end else begin
                in_valid = 1'b0;
            end
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL stream_drain out_valid: got %b want 0", out_valid);
        end
    endtask

    task automatic test_random();
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  c;
        for (int i = 0; i < 40; i++) begin
            a = $urandom;
            b = ($urandom_range(0, 3) == 0) ? a : $urandom;
            c = 4'($urandom_range(0, 15));
            run_op(a, b, c, $sformatf("rand_%0d_op%0d", i, c));
        end
    endtask

    initial begin
        test_reset();
        test_arith();
        test_shift();
        test_boundaries();
        test_mul();
        test_backpressure();
        test_back_to_back();
        test_random();
        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
